// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC and fetches over req/ack; zero-wait ack gives 1 instr/cycle, else NOP bubbles.
// Backpressure: !en parks the fetched word in a buffer (HOLD) with no new request. Optional counters: FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        fetch_valid,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_busy,
  output logic [31:0] perf_discard
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_buf;
  logic [31:0] pend_pc;

  // pc is frozen in DRAIN, so it still names the request being drained.
  assign PCF       = pc;
  assign PCPlus4F  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state != S_HOLD);

  assign fetch_valid = !redirect &&
                       ((state == S_HOLD) || (state == S_REQ && imem_ack));
  assign InstrF      = (state == S_HOLD) ? instr_buf :
                       (fetch_valid ? imem_rdata : NOP_INSTR);
  assign fetch_busy  = (state == S_REQ && !imem_ack) || (state == S_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      instr_buf <= NOP_INSTR;
      pend_pc   <= 32'h0;
    end else if (redirect) begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            pc <= PCTargetE;
          end else begin
            pend_pc <= PCTargetE;
            state   <= S_DRAIN;
          end
        end
        S_HOLD: begin
          pc    <= PCTargetE;
          state <= S_REQ;
        end
        S_DRAIN: begin
          pend_pc <= PCTargetE;
          if (imem_ack) begin
            pc    <= PCTargetE;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            if (en) begin
              pc <= pc + 32'd4;
            end else begin
              instr_buf <= imem_rdata;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (en) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            pc    <= pend_pc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic discard_ack;
  assign discard_ack = imem_ack && ((state == S_DRAIN) || (state == S_REQ && redirect));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_busy    <= 32'h0;
      perf_discard <= 32'h0;
    end else begin
      if (fetch_valid && en && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (fetch_busy && perf_busy != 32'hFFFF_FFFF)
        perf_busy <= perf_busy + 32'd1;
      if (discard_ack && perf_discard != 32'hFFFF_FFFF)
        perf_discard <= perf_discard + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fetch-semantics model checked every cycle plus literal expectations.
module tb_fetch_unit;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, redirect, imem_ack;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, fetch_valid, fetch_busy;
  logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_busy, perf_discard;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .en(en), .redirect(redirect), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .fetch_valid(fetch_valid), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_busy(perf_busy), .perf_discard(perf_discard)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the fetch stage either owns a parked word, is waiting out a
  // response that will be thrown away, or is simply waiting for memory.
  logic [31:0] m_pc, m_buf, m_pend;
  logic        m_parked, m_draining;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_buf = NOP; m_pend = 32'h0;
      m_parked = 1'b0; m_draining = 1'b0;
    end else if (redirect) begin
      if (m_parked) begin
        m_parked = 1'b0; m_pc = PCTargetE;
      end else if (imem_ack) begin
        m_draining = 1'b0; m_pc = PCTargetE;
      end else begin
        m_draining = 1'b1; m_pend = PCTargetE;
      end
    end else if (m_parked) begin
      if (en) begin m_parked = 1'b0; m_pc = m_pc + 32'd4; end
    end else if (imem_ack) begin
      if (m_draining) begin
        m_draining = 1'b0; m_pc = m_pend;
      end else if (en) begin
        m_pc = m_pc + 32'd4;
      end else begin
        m_parked = 1'b1; m_buf = imem_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      logic        e_valid;
      logic [31:0] e_instr;
      e_valid = !redirect && (m_parked || (!m_draining && imem_ack));
      e_instr = m_parked ? m_buf : (e_valid ? imem_rdata : NOP);
      chk("m_req",   {31'b0, imem_req},    {31'b0, !m_parked});
      chk("m_addr",  imem_addr,            m_pc);
      chk("m_pcf",   PCF,                  m_pc);
      chk("m_pc4",   PCPlus4F,             m_pc + 32'd4);
      chk("m_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
      chk("m_instr", InstrF,               e_instr);
      chk("m_busy",  {31'b0, fetch_busy},  {31'b0, !m_parked && (m_draining || !imem_ack)});
    end
  end

  // One cycle: drive inputs just after the rising edge, return just after the falling edge.
  task automatic cyc(input logic e, input logic r, input logic [31:0] tgt, input logic ack);
    @(posedge clk); #1;
    en = e; redirect = r; PCTargetE = tgt; imem_ack = ack;
    imem_rdata = ack ? mem_word(m_pc) : JUNK;
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; redirect = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = JUNK;
    #3;
    chk("rst_req",   {31'b0, imem_req}, 32'd1);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pcf",   PCF, 32'h0);
    chk("rst_pc4",   PCPlus4F, 32'h4);
    #9 reset = 1'b0;

    // Zero-wait memory streams one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1);
      chk("zw_pcf",   PCF, 32'(i * 4));
      chk("zw_valid", {31'b0, fetch_valid}, 32'd1);
      chk("zw_instr", InstrF, 32'hC0DE_0000 + 32'(i * 4));
    end

    // Two wait cycles at 0x10.
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      chk("lat_valid", {31'b0, fetch_valid}, 32'd0);
      chk("lat_instr", InstrF, NOP);
      chk("lat_busy",  {31'b0, fetch_busy}, 32'd1);
      chk("lat_addr",  imem_addr, 32'h10);
    end
    cyc(1, 0, 0, 1);
    chk("lat_done", InstrF, 32'hC0DE_0010);
    chk("lat_addr2", imem_addr, 32'h10);

    // Stall: word at 0x14 parked while en=0.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("hold_req",   {31'b0, imem_req}, 32'd0);
      chk("hold_instr", InstrF, 32'hC0DE_0014);
      chk("hold_pcf",   PCF, 32'h14);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("unhold_pcf", PCF, 32'h18);
    chk("unhold_req", {31'b0, imem_req}, 32'd1);

    // Redirect to 0x100 while 0x1C is outstanding; its response is dropped.
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h100, 0);
    chk("rd_valid", {31'b0, fetch_valid}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("dr_addr", imem_addr, 32'h1C);
    cyc(1, 0, 0, 1);
    chk("dr_addr2", imem_addr, 32'h1C);
    chk("dr_drop",  {31'b0, fetch_valid}, 32'd0);
    chk("dr_nop",   InstrF, NOP);
    cyc(1, 0, 0, 1);
    chk("dr_tgt",   imem_addr, 32'h100);
    chk("dr_instr", InstrF, 32'hC0DE_0100);

    // Redirect out of HOLD at 0x20 with en=0.
    cyc(1, 1, 32'h20, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h40, 0);
    chk("hr_valid", {31'b0, fetch_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("hr_pcf", PCF, 32'h40);
    chk("hr_req", {31'b0, imem_req}, 32'd1);

    // DRAIN: latest target wins; ack with a redirect takes the new target.
    cyc(0, 1, 32'h80, 0);
    cyc(0, 1, 32'h92, 0);
    cyc(0, 0, 0, 0);
    chk("lw_addr", imem_addr, 32'h40);
    cyc(0, 1, 32'hA2, 1);
    cyc(1, 0, 0, 1);
    chk("lw_pcf", PCF, 32'hA2);

    // PC wraparound.
    cyc(1, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 1);
    chk("wr_pcf", PCF, 32'hFFFF_FFFC);
    chk("wr_pc4", PCPlus4F, 32'h0);
    cyc(1, 0, 0, 0);
    chk("wr_pcf2", PCF, 32'h0);

    // Reset asserted mid-DRAIN takes effect immediately.
    cyc(1, 1, 32'h200, 0);
    cyc(1, 0, 0, 0);
    reset = 1'b1; #1;
    chk("ar_pcf",   PCF, 32'h0);
    chk("ar_valid", {31'b0, fetch_valid}, 32'd0);
    chk("ar_req",   {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    cyc(1, 0, 0, 1);
    chk("ar_fetch", InstrF, 32'hC0DE_0000);
    cyc(1, 0, 0, 1);
    chk("ar_next", PCF, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
